icache_nway: RTL and testbench



---
 rtl/icache_nway_if.sv | 26 ++
 rtl/icache_nway.sv | 146 ++++++++++++++
 tb/tb_icache_nway.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/icache_nway_if.sv
// Fetch/fill bus between the core fetch stage, the network fill path and icache_nway.
// The slave modport is the cache side; the master modport is the requester side.
interface icache_nway_if #(
    parameter int pc_width_p = 21
);
    logic                  v_i;
    logic                  w_i;
    logic                  flush_i;
    logic [pc_width_p-1:0] w_pc_i;
    logic [31:0]           w_instr_i;
    logic [pc_width_p-1:0] pc_i;
    logic [31:0]           instr_o;
    logic [pc_width_p-1:0] pc_r_o;
    logic                  icache_miss_o;
    logic                  fill_done_o;

    modport slave (
        input  v_i, w_i, flush_i, w_pc_i, w_instr_i, pc_i,
        output instr_o, pc_r_o, icache_miss_o, fill_done_o
    );

    modport master (
        output v_i, w_i, flush_i, w_pc_i, w_instr_i, pc_i,
        input  instr_o, pc_r_o, icache_miss_o, fill_done_o
    );
endinterface

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with per-line valid bits, single-cycle flush,
// sequential block fill and invalid-first / per-set round-robin replacement.
module icache_nway #(
    parameter int icache_tag_width_p           = 12,
    parameter int icache_entries_p             = 1024,
    parameter int icache_block_size_in_words_p = 4,
    parameter int icache_ways_p                = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    icache_nway_if.slave    bus
);
    localparam int sets_lp     = icache_entries_p / (icache_block_size_in_words_p * icache_ways_p);
    localparam int set_w_lp    = $clog2(sets_lp);
    localparam int off_w_lp    = $clog2(icache_block_size_in_words_p);
    localparam int way_w_lp    = $clog2(icache_ways_p);
    localparam int pc_width_lp = icache_tag_width_p + set_w_lp + off_w_lp;
    localparam int blk_w_lp    = 32 * icache_block_size_in_words_p;
    localparam logic [off_w_lp-1:0] last_off_lp = off_w_lp'(icache_block_size_in_words_p - 1);

    function automatic logic [set_w_lp-1:0] set_of(input logic [pc_width_lp-1:0] pc);
        return pc[off_w_lp +: set_w_lp];
    endfunction

    function automatic logic [icache_tag_width_p-1:0] tag_of(input logic [pc_width_lp-1:0] pc);
        return pc[pc_width_lp-1 -: icache_tag_width_p];
    endfunction

    // Arrays and their latched read ports
    logic [icache_tag_width_p-1:0] tag_mem  [icache_ways_p][sets_lp];
    logic [blk_w_lp-1:0]           data_mem [icache_ways_p][sets_lp];
    logic [icache_tag_width_p-1:0] r_tag_rd  [icache_ways_p];
    logic [blk_w_lp-1:0]           r_data_rd [icache_ways_p];
    logic [31:0]                   r_buf     [icache_block_size_in_words_p];

    logic [sets_lp-1:0]            r_valid [icache_ways_p];
    logic [way_w_lp-1:0]           r_rr    [sets_lp];
    logic [off_w_lp-1:0]           r_wcnt;
    logic [pc_width_lp-1:0]        r_pc_r;
    logic                          r_stale;
    logic                          r_fill_done;

    logic                          w_fill;
    logic                          w_read;
    logic                          w_last;
    logic [set_w_lp-1:0]           w_fill_set;
    logic [set_w_lp-1:0]           w_rd_set;
    logic                          w_has_inv;
    logic [way_w_lp-1:0]           w_victim;
    logic [blk_w_lp-1:0]           w_fill_block;
    logic [icache_ways_p-1:0]      w_hit;
    logic [31:0]                   w_instr;

    assign w_fill     = ~bus.flush_i & bus.v_i & bus.w_i;
    assign w_read     = ~bus.flush_i & bus.v_i & ~bus.w_i;
    assign w_last     = w_fill && (r_wcnt == last_off_lp);
    assign w_fill_set = set_of(bus.w_pc_i);
    assign w_rd_set   = set_of(r_pc_r);

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_has_inv = 1'b0;
        w_victim  = r_rr[w_fill_set];
        for (int k = icache_ways_p - 1; k >= 0; k--) begin
            if (!r_valid[k][w_fill_set]) begin
                w_has_inv = 1'b1;
                w_victim  = way_w_lp'(k);
            end
        end
    end

    always_comb begin
        w_fill_block = '0;
        for (int i = 0; i < icache_block_size_in_words_p - 1; i++) begin
            w_fill_block[i*32 +: 32] = r_buf[i];
        end
        w_fill_block[blk_w_lp-1 -: 32] = bus.w_instr_i;
    end

    always_comb begin
        w_instr = '0;
        for (int k = 0; k < icache_ways_p; k++) begin
            w_hit[k] = r_valid[k][w_rd_set] && (r_tag_rd[k] == tag_of(r_pc_r));
            w_instr  = w_instr | ({32{w_hit[k]}} & r_data_rd[k][32*r_pc_r[off_w_lp-1:0] +: 32]);
        end
    end

    // NOTE: array contents, read latches and the fill buffer carry no reset; valid bits and the
    // write counter alone decide whether anything stored in them is meaningful.
    always_ff @(posedge clk_i) begin
        if (w_fill && !w_last) begin
            r_buf[r_wcnt] <= bus.w_instr_i;
        end
        if (w_last) begin
            tag_mem[w_victim][w_fill_set]  <= tag_of(bus.w_pc_i);
            data_mem[w_victim][w_fill_set] <= w_fill_block;
        end
        if (w_read) begin
            for (int k = 0; k < icache_ways_p; k++) begin
                r_tag_rd[k]  <= tag_mem[k][set_of(bus.pc_i)];
                r_data_rd[k] <= data_mem[k][set_of(bus.pc_i)];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < icache_ways_p; k++) r_valid[k] <= '0;
            for (int s = 0; s < sets_lp; s++) r_rr[s] <= '0;
            r_wcnt      <= '0;
            r_pc_r      <= '0;
            r_stale     <= 1'b1;
            r_fill_done <= 1'b0;
        end else begin
            r_fill_done <= w_last;
            if (bus.flush_i) begin
                for (int k = 0; k < icache_ways_p; k++) r_valid[k] <= '0;
                for (int s = 0; s < sets_lp; s++) r_rr[s] <= '0;
                r_wcnt  <= '0;
                r_stale <= 1'b1;
            end else if (w_fill) begin
                r_wcnt <= r_wcnt + 1'b1;
                if (w_last) begin
                    r_valid[w_victim][w_fill_set] <= 1'b1;
                    if (!w_has_inv) r_rr[w_fill_set] <= r_rr[w_fill_set] + 1'b1;
                    r_stale <= 1'b1;
                end
            end else if (w_read) begin
                r_pc_r  <= bus.pc_i;
                r_stale <= 1'b0;
            end
        end
    end

    // Fill words must arrive in order, and a tag may live in only one way of a set
    always_ff @(posedge clk_i) begin
        if (!reset_i && w_fill) assert (bus.w_pc_i[off_w_lp-1:0] == r_wcnt);
        if (!reset_i && !r_stale) assert ($onehot0(w_hit));
    end

    assign bus.instr_o       = w_instr;
    assign bus.pc_r_o        = r_pc_r;
    assign bus.icache_miss_o = ~(|w_hit) | r_stale;
    assign bus.fill_done_o   = r_fill_done;
endmodule

// File: tb/tb_icache_nway.sv
// Directed self-checking bench for icache_nway at default parameters
// (set = pc[8:2], tag = pc[20:9]).
module tb_icache_nway;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    icache_nway_if #(.pc_width_p(21)) bus ();

    icache_nway dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [20:0] pc);
        bus.v_i  = 1'b1;
        bus.w_i  = 1'b0;
        bus.pc_i = pc;
        tick();
        bus.v_i  = 1'b0;
    endtask

    task automatic fill_words(input logic [20:0] base, input logic [31:0] dbase, input int n);
        for (int i = 0; i < n; i++) begin
            bus.v_i       = 1'b1;
            bus.w_i       = 1'b1;
            bus.w_pc_i    = base + 21'(i);
            bus.w_instr_i = dbase + 32'(i);
            tick();
        end
        bus.v_i = 1'b0;
        bus.w_i = 1'b0;
    endtask

    task automatic read_hit(input string tag, input logic [20:0] pc, input logic [31:0] exp);
        do_read(pc);
        check({tag, "_miss"}, 32'(bus.icache_miss_o), 32'd0);
        check({tag, "_instr"}, bus.instr_o, exp);
    endtask

    task automatic read_miss(input string tag, input logic [20:0] pc);
        do_read(pc);
        check({tag, "_miss"}, 32'(bus.icache_miss_o), 32'd1);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.v_i       = 1'b0;
        bus.w_i       = 1'b0;
        bus.flush_i   = 1'b0;
        bus.w_pc_i    = '0;
        bus.w_instr_i = '0;
        bus.pc_i      = '0;
        tick();
        check("rst_miss", 32'(bus.icache_miss_o), 32'd1);
        check("rst_pc_r", 32'(bus.pc_r_o), 32'h0);
        check("rst_fill_done", 32'(bus.fill_done_o), 32'd0);
        rst = 1'b0;
        tick();

        // Cold read, then a first block fill
        read_miss("cold", 21'h000);
        check("cold_pc_r", 32'(bus.pc_r_o), 32'h000);
        fill_words(21'h000, 32'h0000_0A00, 4);
        check("fill_done_pulse", 32'(bus.fill_done_o), 32'd1);
        check("stale_after_fill", 32'(bus.icache_miss_o), 32'd1);
        tick();
        check("fill_done_drop", 32'(bus.fill_done_o), 32'd0);
        read_hit("rd002", 21'h002, 32'h0000_0A02);
        read_hit("rd003", 21'h003, 32'h0000_0A03);

        // Three then four tags into set 0: invalid-first, then round-robin
        reset_pulse();
        fill_words(21'h000, 32'h0000_0100, 4);
        fill_words(21'h200, 32'h0000_0200, 4);
        fill_words(21'h400, 32'h0000_0400, 4);
        read_miss("evict0_000", 21'h000);
        read_hit("keep_200", 21'h200, 32'h0000_0200);
        read_hit("new_401", 21'h401, 32'h0000_0401);
        fill_words(21'h600, 32'h0000_0600, 4);
        read_miss("evict1_200", 21'h200);
        read_hit("keep_400", 21'h400, 32'h0000_0400);
        read_hit("new_603", 21'h603, 32'h0000_0603);

        // Install elsewhere makes the held output stale until the next read
        read_hit("pre_402", 21'h402, 32'h0000_0402);
        tick();
        check("hold_miss", 32'(bus.icache_miss_o), 32'd0);
        check("hold_instr", bus.instr_o, 32'h0000_0402);
        fill_words(21'h010, 32'h0000_0010, 4);
        check("stale_miss", 32'(bus.icache_miss_o), 32'd1);
        check("stale_pc_r", 32'(bus.pc_r_o), 32'h402);
        read_hit("reread_402", 21'h402, 32'h0000_0402);

        // Flush mid-fill, with a concurrent read that must be dropped
        fill_words(21'h000, 32'h0000_0700, 2);
        bus.flush_i = 1'b1;
        bus.v_i     = 1'b1;
        bus.w_i     = 1'b0;
        bus.pc_i    = 21'h010;
        tick();
        bus.flush_i = 1'b0;
        bus.v_i     = 1'b0;
        check("flush_pc_r", 32'(bus.pc_r_o), 32'h402);
        check("flush_miss", 32'(bus.icache_miss_o), 32'd1);
        fill_words(21'h000, 32'h0000_0800, 4);
        check("refill_done", 32'(bus.fill_done_o), 32'd1);
        read_hit("refill_001", 21'h001, 32'h0000_0801);
        read_hit("refill_000", 21'h000, 32'h0000_0800);
        read_miss("flushed_400", 21'h400);
        read_miss("flushed_600", 21'h600);
        read_miss("flushed_010", 21'h010);

        // Asynchronous reset between edges in the middle of a fill
        read_miss("pre_rst_011", 21'h011);
        check("pre_rst_pc_r", 32'(bus.pc_r_o), 32'h011);
        fill_words(21'h020, 32'h0000_0900, 2);
        #3;
        rst = 1'b1;
        #1;
        check("async_miss", 32'(bus.icache_miss_o), 32'd1);
        check("async_pc_r", 32'(bus.pc_r_o), 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_fill_done", 32'(bus.fill_done_o), 32'd0);
        end
        read_miss("post_rst_000", 21'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
